// File: rtl/ct_byte_packer.sv
// ct_byte_packer: packs the serial ciphertext bit stream into bytes (first bit
// lands in bit 7), buffers them in a small FIFO, and hands them out on a
// valid/ready byte port. Tracks bytes popped per frame, frame completion and
// sticky overflow.
// Optional feature macro: A51_PACK_CKSUM_EN enables a running XOR checksum of
// popped bytes; without it the cksum port is tied to 8'h00.
module ct_byte_packer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_BYTES = 65536,
    parameter int CNT_W       = 17
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic                          bit_valid,
    input  logic                          ct,
    output logic [7:0]                    byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              byte_count,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [7:0]                    cksum
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [2:0]       r_bidx;
    logic [6:0]       r_shift;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [CNT_W-1:0] r_byte_count;
    logic             r_overflow;

    logic [AW:0]      w_level;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_bit_take;
    logic             w_push;
    logic             w_push_ok;
    logic             w_count_pop;
    logic             w_last_pop;
    logic [7:0]       w_byte;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (w_level == '0);
    assign w_full      = (w_level == (AW+1)'(FIFO_DEPTH));
    assign w_pop       = ~w_empty & byte_ready;
    assign w_bit_take  = bit_valid & (r_state == S_RUN);
    assign w_byte      = {r_shift, ct};
    assign w_push      = w_bit_take & (r_bidx == 3'd7);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok   = w_push & (~w_full | w_pop);
    // Only pops belonging to the running frame count toward it.
    assign w_count_pop = w_pop & (r_state == S_RUN);
    assign w_last_pop  = w_count_pop & (r_byte_count == CNT_W'(FRAME_BYTES - 1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: frame_start restarts from any state.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        if (frame_start) begin
            w_state_nxt = S_RUN;
        end else if (r_state == S_RUN && w_last_pop) begin
            w_state_nxt = S_DONE;
        end
    end

    // Bit stage: collect bits MSB-first; a bit arriving with frame_start opens the new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bidx  <= 3'd0;
            r_shift <= 7'd0;
        end else if (frame_start) begin
            r_bidx  <= bit_valid ? 3'd1 : 3'd0;
            r_shift <= {6'd0, bit_valid & ct};
        end else if (w_bit_take) begin
            r_bidx  <= r_bidx + 3'd1;
            r_shift <= {r_shift[5:0], ct};
        end
    end

    // FIFO pointers: flushed by frame_start, otherwise advanced by push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (frame_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // FIFO storage write.
    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (!frame_start && w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= w_byte;
    end

    // Frame byte counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_count <= '0;
            r_overflow   <= 1'b0;
        end else if (frame_start) begin
            r_byte_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_count_pop)                r_byte_count <= r_byte_count + 1'b1;
            if (w_push && w_full && !w_pop) r_overflow   <= 1'b1;
        end
    end

`ifdef A51_PACK_CKSUM_EN
    logic [7:0] r_cksum;

    // Running XOR of every byte popped in the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_cksum <= 8'h00;
        else if (frame_start) r_cksum <= 8'h00;
        else if (w_count_pop) r_cksum <= r_cksum ^ byte_data;
    end

    assign cksum = r_cksum;
`else
    assign cksum = 8'h00;
`endif

    // Head byte is masked to zero when nothing is buffered.
    assign byte_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
    assign byte_valid = ~w_empty;
    assign fifo_level = w_level;
    assign byte_count = r_byte_count;
    assign frame_done = (r_state == S_DONE);
    assign overflow   = r_overflow;

endmodule
